// File: rtl/axis_block_pkg.sv
// Shared definitions for block-oriented AXI4-Stream blocks.
//   arb_state_t  : arbiter states (IDLE, GRANT0, GRANT1)
//   count_width  : width of a beat counter covering 0..block_size-1
//   is_pow2      : legality check for block-size parameters
package axis_block_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  function automatic int count_width(input int block_size);
    return (block_size > 1) ? $clog2(block_size) : 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 1) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_skid.sv
// Two-entry register buffer for a valid/ready stream.
// All outputs come straight from flops. The input ready is registered and
// means "second entry will be empty", so a beat offered while ready is high
// always has somewhere to go even if the output stalls in the same cycle.
// Ports:
//   aclk, aresetn            clock, async active-low reset
//   s_valid/s_ready/s_data   upstream side
//   m_valid/m_ready/m_data   downstream side (data0 drives m_*)
module axis_skid #(
  parameter int WIDTH = 10
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic [WIDTH-1:0] data0, data1, data0_n, data1_n;
  logic             valid0, valid1, valid0_n, valid1_n;
  logic             ready_q;
  logic             push, pop;

  assign push = s_valid && ready_q;
  assign pop  = valid0 && m_ready;

  always_comb begin
    data0_n  = data0;
    data1_n  = data1;
    valid0_n = valid0;
    valid1_n = valid1;
    if (pop) begin
      if (valid1) begin
        // ready_q was low, so no push can coincide here
        data0_n  = data1;
        valid0_n = 1'b1;
        valid1_n = 1'b0;
      end else if (push) begin
        data0_n  = s_data;
        valid0_n = 1'b1;
      end else begin
        valid0_n = 1'b0;
      end
    end else if (push) begin
      if (!valid0) begin
        data0_n  = s_data;
        valid0_n = 1'b1;
      end else begin
        data1_n  = s_data;
        valid1_n = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data0   <= '0;
      data1   <= '0;
      valid0  <= 1'b0;
      valid1  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      data0   <= data0_n;
      data1   <= data1_n;
      valid0  <= valid0_n;
      valid1  <= valid1_n;
      ready_q <= !valid1_n;
    end
  end

  assign s_ready = ready_q;
  assign m_valid = valid0;
  assign m_data  = data0;

endmodule

// File: rtl/axis_block_arbiter.sv
// Two-input AXI4-Stream arbiter that hands the output to one source for a
// whole block. A block ends on the owner's tlast or after BLOCK_SIZE beats,
// whichever comes first; that beat leaves with m_axis_tlast=1. Ties in IDLE
// go to the source not granted last (s0 wins the first tie).
// Ports:
//   aclk, aresetn                         clock, async active-low reset
//   s0_axis_*, s1_axis_*                  requester streams
//   m_axis_tdata/tlast/tid/tvalid/tready  shared block stream, tid = source
//   grant                                 one-hot owner, 00 when idle
module axis_block_arbiter
  import axis_block_pkg::*;
#(
  parameter int BLOCK_SIZE = 512,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tlast,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tlast,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tid,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [1:0]            grant
);

  localparam int CW = count_width(BLOCK_SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_SIZE - 1);

  if (!is_pow2(BLOCK_SIZE)) begin : g_size_check
    $error("axis_block_arbiter: BLOCK_SIZE must be a power of two greater than 1");
  end

  arb_state_t            state, state_n;
  logic [CW-1:0]         count;
  logic                  last_grant;
  logic                  own_valid, own_last, own_id;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  skid_ready;
  logic                  accept, block_end;
  logic [DATA_WIDTH+1:0] skid_out;

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    own_id    = 1'b0;
    case (state)
      GRANT0: begin
        own_valid = s0_axis_tvalid;
        own_last  = s0_axis_tlast;
        own_data  = s0_axis_tdata;
        own_id    = 1'b0;
      end
      GRANT1: begin
        own_valid = s1_axis_tvalid;
        own_last  = s1_axis_tlast;
        own_data  = s1_axis_tdata;
        own_id    = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept    = own_valid && skid_ready;
  // Source tlast and a full count on the same beat form one boundary.
  assign block_end = own_last || (count == CNT_LAST);

  assign s0_axis_tready = (state == GRANT0) && skid_ready;
  assign s1_axis_tready = (state == GRANT1) && skid_ready;
  assign grant          = {state == GRANT1, state == GRANT0};

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid)
          state_n = last_grant ? GRANT0 : GRANT1;
        else if (s0_axis_tvalid)
          state_n = GRANT0;
        else if (s1_axis_tvalid)
          state_n = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (accept && block_end)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      count      <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_n;
      if (accept) begin
        count <= block_end ? '0 : count + 1'b1;
        if (block_end)
          last_grant <= own_id;
      end
    end
  end

  axis_skid #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (own_valid),
    .s_ready (skid_ready),
    .s_data  ({own_id, block_end, own_data}),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (skid_out)
  );

  assign m_axis_tid   = skid_out[DATA_WIDTH+1];
  assign m_axis_tlast = skid_out[DATA_WIDTH];
  assign m_axis_tdata = skid_out[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_axis_block_arbiter.sv
module tb_axis_block_arbiter;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] s0_data = '0, s1_data = '0;
  logic       s0_last = 1'b0, s1_last = 1'b0;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic       s0_ready, s1_ready;
  logic [7:0] m_data;
  logic       m_last, m_tid, m_valid;
  logic       m_ready = 1'b1;
  logic [1:0] grant;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  typedef struct packed {
    logic       tid;
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic       s0v;
    logic [7:0] s0d;
    logic       s0l;
    logic [1:0] e_grant;
    logic       e_s0r;
    logic       e_mv;
    logic [7:0] e_md;
    logic       e_ml;
    logic       e_tid;
  } vec_t;

  beat_t out_q[$];
  int    out_cyc[$];
  beat_t exp_q[$];
  vec_t  vecs[6];

  axis_block_arbiter #(.BLOCK_SIZE(4), .DATA_WIDTH(8)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s0_axis_tdata  (s0_data),
    .s0_axis_tlast  (s0_last),
    .s0_axis_tvalid (s0_valid),
    .s0_axis_tready (s0_ready),
    .s1_axis_tdata  (s1_data),
    .s1_axis_tlast  (s1_last),
    .s1_axis_tvalid (s1_valid),
    .s1_axis_tready (s1_ready),
    .m_axis_tdata   (m_data),
    .m_axis_tlast   (m_last),
    .m_axis_tid     (m_tid),
    .m_axis_tvalid  (m_valid),
    .m_axis_tready  (m_ready),
    .grant          (grant)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  always @(posedge aclk) begin
    #1;
    if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor and hold-while-stalled check
  bit    prev_stall = 1'b0;
  beat_t prev_beat;
  always @(negedge aclk) begin
    if (aresetn && m_valid && m_ready) begin
      out_q.push_back({m_tid, m_last, m_data});
      out_cyc.push_back(cyc);
    end
    if (aresetn && prev_stall) begin
      tests++;
      if (!(m_valid && ({m_tid, m_last, m_data} == prev_beat))) begin
        fails++;
        $display("FAIL hold: got valid=%0b beat=%h required valid=1 beat=%h",
                 m_valid, {m_tid, m_last, m_data}, prev_beat);
      end
    end
    prev_stall = aresetn && m_valid && !m_ready;
    prev_beat  = {m_tid, m_last, m_data};
  end

  initial begin
    repeat (20000) @(posedge aclk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Send n beats from one source; bit i of last_mask sets tlast on beat i.
  task automatic drive(input int src, input int n, input logic [7:0] base, input int last_mask);
    logic r;
    int   w;
    for (int i = 0; i < n; i++) begin
      if (src == 0) begin
        s0_valid = 1'b1; s0_data = base + 8'(i); s0_last = last_mask[i];
      end else begin
        s1_valid = 1'b1; s1_data = base + 8'(i); s1_last = last_mask[i];
      end
      w = 0;
      do begin
        @(negedge aclk);
        r = (src == 0) ? s0_ready : s1_ready;
        @(posedge aclk);
        w++;
      end while (!r && w < 200);
      if (!r) chk($sformatf("drive_timeout_s%0d", src), 32'(w), 32'(0));
      #1;
    end
    if (src == 0) begin s0_valid = 1'b0; s0_last = 1'b0; end
    else begin s1_valid = 1'b0; s1_last = 1'b0; end
  endtask

  task automatic add_exp(input logic tid, input logic last, input logic [7:0] d);
    exp_q.push_back({tid, last, d});
  endtask

  task automatic clear_q();
    out_q.delete();
    out_cyc.delete();
    exp_q.delete();
  endtask

  task automatic wait_and_compare(input string name);
    int c = 0;
    while (out_q.size() < exp_q.size() && c < 500) begin
      @(posedge aclk);
      c++;
    end
    repeat (3) @(posedge aclk);
    chk({name, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < out_q.size())
        chk($sformatf("%s_beat%0d", name, i), 32'(out_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    //               s0v  s0d    s0l  grant  s0r  mv   md     ml   tid
    vecs[0] = '{1'b1, 8'hA1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hA1, 1'b0, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'hB2, 1'b0, 2'b01, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'hC3, 1'b1, 2'b01, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_ready", 32'({s0_ready, s1_ready}), 32'(0));
    chk("rst_mout", 32'({m_valid, m_last, m_tid, m_data}), 32'(0));
    @(negedge aclk) aresetn = 1'b1;

    // Three-beat s0 block, cycle-accurate table
    for (int i = 0; i < 6; i++) begin
      @(posedge aclk);
      #1;
      s0_valid = vecs[i].s0v; s0_data = vecs[i].s0d; s0_last = vecs[i].s0l;
      @(negedge aclk);
      chk($sformatf("vec%0d_ctl", i), 32'({grant, s0_ready, s1_ready, m_valid}),
          32'({vecs[i].e_grant, vecs[i].e_s0r, 1'b0, vecs[i].e_mv}));
      if (vecs[i].e_mv)
        chk($sformatf("vec%0d_data", i), 32'({m_tid, m_last, m_data}),
            32'({vecs[i].e_tid, vecs[i].e_ml, vecs[i].e_md}));
    end

    // s1 streams 10 beats, tlast only on the 10th -> blocks 4,4,2
    clear_q();
    for (int i = 0; i < 10; i++) add_exp(1'b1, (i == 3 || i == 7 || i == 9), 8'h10 + 8'(i));
    drive(1, 10, 8'h10, 32'h200);
    wait_and_compare("s1_ten");
    for (int i = 1; i < 10; i++)
      if (i < out_cyc.size())
        chk($sformatf("s1_ten_gap%0d", i), 32'(out_cyc[i] - out_cyc[i-1]),
            (i == 4 || i == 8) ? 32'(2) : 32'(1));

    // Both sources valid from reset: round robin, s0 first
    clear_q();
    aresetn = 1'b0;
    for (int i = 0; i < 4; i++) add_exp(1'b0, i == 3, 8'h20 + 8'(i));
    for (int i = 0; i < 4; i++) add_exp(1'b1, i == 3, 8'h30 + 8'(i));
    for (int i = 4; i < 8; i++) add_exp(1'b0, i == 7, 8'h20 + 8'(i));
    for (int i = 4; i < 8; i++) add_exp(1'b1, i == 7, 8'h30 + 8'(i));
    fork
      drive(0, 8, 8'h20, 0);
      drive(1, 8, 8'h30, 0);
      begin repeat (2) @(posedge aclk); @(negedge aclk) aresetn = 1'b1; end
    join
    wait_and_compare("rr");

    // Random backpressure during a 16-beat s0 stream
    clear_q();
    for (int i = 0; i < 16; i++) add_exp(1'b0, (i % 4) == 3, 8'h40 + 8'(i));
    rand_rdy = 1'b1;
    drive(0, 16, 8'h40, 0);
    begin
      int c = 0;
      while (out_q.size() < 16 && c < 500) begin @(posedge aclk); c++; end
    end
    rand_rdy = 1'b0;
    @(posedge aclk);
    #2 m_ready = 1'b1;
    wait_and_compare("bp");

    // tlast coinciding with the 4th beat: one boundary, count restarts
    clear_q();
    for (int i = 0; i < 9; i++) add_exp(1'b0, (i == 3 || i == 7 || i == 8), 8'h60 + 8'(i));
    drive(0, 9, 8'h60, 32'h108);
    wait_and_compare("tl4");
    if (out_cyc.size() >= 6) begin
      chk("tl4_gap4", 32'(out_cyc[4] - out_cyc[3]), 32'(2));
      chk("tl4_gap5", 32'(out_cyc[5] - out_cyc[4]), 32'(1));
    end

    // Reset after two beats of an s1 block
    clear_q();
    begin
      int acc = 0;
      int w = 0;
      logic r;
      s1_valid = 1'b1; s1_data = 8'h70; s1_last = 1'b0;
      while (acc < 2 && w < 50) begin
        @(negedge aclk);
        r = s1_ready;
        @(posedge aclk);
        w++;
        if (r) begin acc++; #1 s1_data = 8'h71; end
      end
      chk("mid_rst_accepts", 32'(acc), 32'(2));
    end
    aresetn = 1'b0;
    s1_valid = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'(0));
    chk("mid_rst_ready", 32'({s0_ready, s1_ready}), 32'(0));
    chk("mid_rst_mout", 32'({m_valid, m_last, m_tid, m_data}), 32'(0));
    @(negedge aclk) aresetn = 1'b1;
    clear_q();
    for (int i = 0; i < 4; i++) add_exp(1'b0, i == 3, 8'h80 + 8'(i));
    fork
      drive(0, 4, 8'h80, 0);
      begin
        int c = 0;
        while (grant == 2'b00 && c < 50) begin @(negedge aclk); c++; end
        chk("post_rst_grant", 32'(grant), 32'(2'b01));
      end
    join
    wait_and_compare("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
